// File: rtl/reg_write_scatter.sv
// Burst write scatter into a 32-entry register bank, exposed as a flat bus for the read muxes.
// Optional build macro REG_SCATTER_R0_ZERO_EN hardwires register 0 to zero.
module reg_write_scatter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           CMD_VALID,
  output logic                           CMD_READY,
  input  logic [ADDR_WIDTH-1:0]          CMD_ADDR,
  input  logic [ADDR_WIDTH-1:0]          CMD_LEN,
  input  logic                           DATA_VALID,
  output logic                           DATA_READY,
  input  logic [DATA_WIDTH-1:0]          DATA,
  output logic                           BUSY,
  output logic                           DONE,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REG_Q
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr, addr_nxt;
  logic [ADDR_WIDTH-1:0]   rem, rem_nxt;
  logic                    done_p0, done_nxt;
  logic                    beat_acc;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

  assign CMD_READY  = (state == IDLE);
  assign DATA_READY = (state == BURST);
  assign BUSY       = (state == BURST);
  assign DONE       = done_p0;
  assign beat_acc   = (state == BURST) && DATA_VALID;

`ifdef REG_SCATTER_R0_ZERO_EN
  // Beats aimed at register 0 are still consumed, just not stored.
  assign wr_en = beat_acc && (addr != '0);
`else
  assign wr_en = beat_acc;
`endif

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    rem_nxt   = rem;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (CMD_VALID) begin
          addr_nxt  = CMD_ADDR;
          rem_nxt   = CMD_LEN;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (DATA_VALID) begin
          // NUM_REGS == 2**ADDR_WIDTH, so natural overflow gives the wrap.
          addr_nxt = addr + 1'b1;
          if (rem == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            rem_nxt = rem - 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state boundary
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      addr    <= '0;
      rem     <= '0;
      done_p0 <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr    <= addr_nxt;
      rem     <= rem_nxt;
      done_p0 <= done_nxt;
    end
  end

  // Register bank boundary
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else if (wr_en) begin
      regs[addr] <= DATA;
    end
  end

  always_comb begin
    REG_Q = '0;
    for (int k = 0; k < NUM_REGS; k++) REG_Q[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
`ifdef REG_SCATTER_R0_ZERO_EN
    REG_Q[DATA_WIDTH-1:0] = '0;
`endif
  end

endmodule

// File: doc/reg_write_scatter.md
Name: reg_write_scatter

Overview:
- Write-side counterpart of the 32-to-1 read selection path: scatters 32-bit words into a bank of 32 registers.
- Accepts a burst command (start address, length), then streams data beats into consecutive registers with auto-increment and wrap.
- All register contents are exposed as one flat bus that feeds the register-file read muxes.
- Sits between the writeback stage / bulk loader and the register-file read path.

Parameters:
DATA_WIDTH, 32, width of each register and data beat
ADDR_WIDTH, 5, register index width
NUM_REGS, 32, register count (must equal 2**ADDR_WIDTH)

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  reset, synchronous, active-high
CMD_VALID  input  1  burst command offered
CMD_READY  output  1  command accepted this cycle when CMD_VALID && CMD_READY
CMD_ADDR  input  ADDR_WIDTH  first register index of burst
CMD_LEN  input  ADDR_WIDTH  beats minus one (0 means 1 beat, 31 means 32 beats)
DATA_VALID  input  1  data beat offered
DATA_READY  output  1  beat accepted when DATA_VALID && DATA_READY
DATA  input  DATA_WIDTH  beat payload
BUSY  output  1  high while in BURST
DONE  output  1  one-cycle pulse after final beat written
REG_Q  output  NUM_REGS*DATA_WIDTH  flat register contents, register k at bits [k*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (RST=1 at a rising edge):
  - All registers clear to 0. State goes to IDLE. Address and remaining-beat counters clear to 0.
  - Outputs after reset: DONE=0, BUSY=0, CMD_READY=1, DATA_READY=0, REG_Q=0.
  - RST has priority over any simultaneous command or beat.
  - Reset during BURST aborts the burst. No DONE is generated for the aborted burst.
- States: IDLE, BURST.
  - CMD_READY = (state==IDLE). DATA_READY = BUSY = (state==BURST). These are combinational decodes of state.
- IDLE:
  - On command accept: latch addr<=CMD_ADDR and rem<=CMD_LEN, then go to BURST.
  - DATA_VALID is ignored in IDLE. No register changes.
- BURST, on beat accept:
  - reg[addr] <= DATA.
  - addr <= addr+1 modulo NUM_REGS (31 wraps to 0).
  - If rem==0: go to IDLE and set DONE=1 for exactly the next cycle.
  - Otherwise: rem <= rem-1.
- BURST with DATA_VALID=0: hold state, addr and rem. No timeout.
- CMD_VALID during BURST is not accepted (CMD_READY=0). The initiator holds it, and it is accepted in the first IDLE cycle, i.e. the cycle after the last beat.
  - Consequence: minimum gap is one cycle between the last beat and the next command, then one more cycle before the first beat.
- Latency: a beat accepted at edge N is visible on REG_Q after edge N (registered, no combinational bypass from DATA to REG_Q).
- A 32-beat burst wraps and rewrites every register exactly once. The final addr equals the start addr.
- Registers not addressed by a burst retain their values.

Optional Feature:
REG_SCATTER_R0_ZERO_EN
- Defined:
  - Register 0 is hardwired to 0. Writes targeting index 0 are discarded.
  - The beat is still consumed (DATA_READY handshake completes) and still counts toward rem and addr increment.
  - REG_Q bits [DATA_WIDTH-1:0] are always 0.
- Undefined: register 0 behaves like every other register.

Test Plan:
- Reset: RST=1 for 2 cycles, then 0 -> REG_Q all 0, CMD_READY=1, DATA_READY=0, BUSY=0, DONE=0.
- Single beat: CMD addr=5, len=0; beat DATA=0xDEADBEEF -> reg5=0xDEADBEEF one edge later; DONE pulses one cycle; state returns to IDLE; all other registers 0.
- Wrap burst with stalls:
  - Stimulus: CMD addr=30, len=3; beats 0x11,0x22,0x33,0x44 with DATA_VALID low for 2 cycles between beats 2 and 3.
  - Response: reg30=0x11, reg31=0x22, reg0=0x33, reg1=0x44; DONE only after the 4th beat; BUSY high throughout.
- Back-to-back:
  - Stimulus: CMD_VALID held high continuously; first CMD addr=8, len=1; second CMD addr=9, len=0.
  - Response: second CMD accepted the cycle after DONE. Beats 0xA,0xB,0xC give reg8=0xA, then reg9=0xB overwritten by 0xC.
  - Also: a DATA_VALID pulse in IDLE changes nothing.
- Reset mid-burst: CMD addr=0, len=31; after 10 beats assert RST -> all registers 0, IDLE, no DONE; a following CMD is accepted normally.
- Macro REG_SCATTER_R0_ZERO_EN: CMD addr=31, len=1, beats 0x5, 0x7 -> reg31=0x5, reg0 stays 0, DONE pulses; without the macro reg0=0x7.
